// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-port register file and its clear sequencer.
package regfile_mp_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

endpackage : regfile_mp_pkg

// File: rtl/regfile_mp_clear_fsm.sv
// Bulk-clear sequencer: walks a pointer over every register, one per cycle,
// and holds busy high for exactly DEPTH cycles.
module rf_clear_fsm
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic [AW-1:0] ptr,
  output logic          clr_we,
  output logic          busy
);

  clr_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
        ST_CLEAR: begin
          // Further clr_req pulses are ignored until the walk completes.
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  assign ptr    = ptr_q;
  assign clr_we = busy_q;
  assign busy   = busy_q;

endmodule : rf_clear_fsm

// File: rtl/regfile_mp.sv
// 2-read/1-write register file with registered reads, optional write bypass,
// optional hardwired-zero R0 and a multi-cycle bulk-clear sequencer.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra_a,
  input  logic [AW-1:0]    ra_b,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b,
  output logic             rd_valid,
  input  logic             clr_req,
  output logic             busy
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_a_q, rd_b_q, rd_a_d, rd_b_d;
  logic             rd_valid_q;
  logic [AW-1:0]    clr_ptr;
  logic             clr_we;
  logic             wr_en;
  logic             rd_acc;

  rf_clear_fsm #(.DEPTH(DEPTH)) u_clr_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .ptr     (clr_ptr),
    .clr_we  (clr_we),
    .busy    (busy)
  );

  // A clear starting on this edge takes priority over a write; R0 may be read-only.
  assign wr_en  = en && we && !busy && !clr_req && !(ZERO_R0 && (wa == '0));
  assign rd_acc = en && !busy;

  assign rd_a_d = (ZERO_R0 && (ra_a == '0))     ? '0 :
                  (BYPASS && wr_en && wa == ra_a) ? wd : mem_q[ra_a];
  assign rd_b_d = (ZERO_R0 && (ra_b == '0))     ? '0 :
                  (BYPASS && wr_en && wa == ra_b) ? wd : mem_q[ra_b];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_we) begin
      mem_q[clr_ptr] <= '0;
    end else if (wr_en) begin
      mem_q[wa] <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_a_q <= rd_a_d;
        rd_b_q <= rd_b_d;
      end
    end
  end

  assign rd_a     = rd_a_q;
  assign rd_b     = rd_b_q;
  assign rd_valid = rd_valid_q;

endmodule : regfile_mp
